// File: rtl/mem_fill_server.sv
// Main-memory responder for the I-cache and D-cache miss ports: round-robin
// arbitration, fixed-latency 8-word block fills and single-word stores.
// Optional CRITICAL_WORD_FIRST_EN: fills start at the requested word and wrap.
module mem_fill_server #(
  parameter int LATENCY     = 4,
  parameter int BLOCK_WORDS = 8,
  parameter int MEM_AW      = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] rdata,
  output logic [2:0]  rword,
  output logic        i_rvalid,
  output logic        d_rvalid,
  output logic        i_done,
  output logic        d_done,
  output logic        d_wack,
  output logic        busy
);

  localparam logic [2:0] LAST_IDX = 3'(BLOCK_WORDS - 1);
  localparam logic [2:0] PENULT_IDX = 3'(BLOCK_WORDS - 2);
  localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, STREAM, WRITE} stateT;

  logic [15:0] mem [0:(1 << MEM_AW) - 1];

  stateT       state;
  logic [3:0]  latCnt;
  logic [2:0]  wordCnt;
  logic [2:0]  nextOff;
  logic [11:0] baseAddr;
  logic        ownerD;
  logic        lastD;

  logic        arbEn;
  logic        grantI;
  logic        grantD;
  logic        loadWord;
  logic        lastWord;
  logic        memWe;
  logic [2:0]  firstOff;
  logic [MEM_AW-1:0] rdAddr;
  logic        unusedBits;

  // Arbitration is open in IDLE and on the closing edge of WRITE or of the
  // last streamed word, which gives back-to-back service with no bubble.
  always_comb begin
    arbEn    = (state == IDLE) || (state == WRITE) ||
               ((state == STREAM) && (wordCnt == LAST_IDX));
    grantI   = arbEn && i_req && (!d_req || lastD);
    grantD   = arbEn && d_req && (!i_req || !lastD);
    loadWord = ((state == WAIT) && (latCnt == 4'd0)) ||
               ((state == STREAM) && (wordCnt != LAST_IDX));
    lastWord = (state == STREAM) && (wordCnt == PENULT_IDX);
    memWe    = rst_n && grantD && d_wr;
  end

`ifdef CRITICAL_WORD_FIRST_EN
  assign firstOff = grantD ? d_addr[3:1] : i_addr[3:1];
`else
  assign firstOff = 3'd0;
`endif

  assign rdAddr     = {baseAddr, nextOff};
  assign unusedBits = ^{i_addr[0], d_addr[0], i_addr[3:1]};

  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[d_addr[15:1]] <= d_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= 16'h0000;
    end else if (loadWord) begin
      rdata <= mem[rdAddr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      latCnt   <= 4'd0;
      wordCnt  <= 3'd0;
      nextOff  <= 3'd0;
      baseAddr <= 12'd0;
      ownerD   <= 1'b0;
      lastD    <= 1'b1;
      rword    <= 3'd0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_done   <= 1'b0;
      d_done   <= 1'b0;
      d_wack   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_done   <= 1'b0;
      d_done   <= 1'b0;
      d_wack   <= 1'b0;

      if ((state == WAIT) && (latCnt != 4'd0)) begin
        latCnt <= latCnt - 4'd1;
      end

      if (loadWord) begin
        rword    <= nextOff;
        nextOff  <= nextOff + 3'd1;
        i_rvalid <= !ownerD;
        d_rvalid <= ownerD;
        i_done   <= !ownerD && lastWord;
        d_done   <= ownerD && lastWord;
        wordCnt  <= (state == WAIT) ? 3'd0 : wordCnt + 3'd1;
        state    <= STREAM;
      end

      if (arbEn) begin
        if (grantI || grantD) begin
          busy     <= 1'b1;
          lastD    <= grantD;
          baseAddr <= grantD ? d_addr[15:4] : i_addr[15:4];
          if (grantD && d_wr) begin
            state  <= WRITE;
            d_wack <= 1'b1;
          end else begin
            state   <= WAIT;
            latCnt  <= LAT_INIT;
            ownerD  <= grantD;
            nextOff <= firstOff;
          end
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_fill_server.sv
// Scoreboard bench for mem_fill_server: drivers push expected responses from a
// word-array model, a negedge monitor pops and compares them.
module tb_mem_fill_server;

  localparam int LAT = 4;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [15:0] i_addr;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] rdata;
  logic [2:0]  rword;
  logic        i_rvalid;
  logic        d_rvalid;
  logic        i_done;
  logic        d_done;
  logic        d_wack;
  logic        busy;

  mem_fill_server #(.LATENCY(LAT), .BLOCK_WORDS(8), .MEM_AW(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .rdata(rdata), .rword(rword),
    .i_rvalid(i_rvalid), .d_rvalid(d_rvalid),
    .i_done(i_done), .d_done(d_done), .d_wack(d_wack), .busy(busy)
  );

  typedef struct {
    logic        wack;
    logic [2:0]  off;
    logic [15:0] data;
    logic        last;
  } expT;

  expT iq[$];
  expT dq[$];
  expT ei;
  expT ed;

  logic [15:0] model [0:32767];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int iBusyLow = 0;

  logic [15:0] iAddrs [16];
  logic        dWrA   [16];
  logic [15:0] dAddrA [16];
  logic [15:0] dDataA [16];
  int iFirst [16];
  int iDone  [16];
  int dFirst [16];
  int dDone  [16];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Expected fill sequence derived from the block/offset rules on the model array.
  task automatic pushFill(input logic [15:0] addr, input bit toD);
    logic [2:0] start;
    logic [2:0] off;
    expT e;
`ifdef CRITICAL_WORD_FIRST_EN
    start = addr[3:1];
`else
    start = 3'd0;
`endif
    for (int j = 0; j < 8; j++) begin
      off    = start + 3'(j);
      e.wack = 1'b0;
      e.off  = off;
      e.data = model[{addr[15:4], off}];
      e.last = (j == 7);
      if (toD) dq.push_back(e);
      else     iq.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (i_rvalid || d_rvalid || i_done || d_done || d_wack) begin
      total++;
      if ((i_rvalid && d_rvalid) || (i_done && !i_rvalid) || (d_done && !d_rvalid) ||
          (d_wack && (d_rvalid || i_rvalid))) begin
        bad++;
        $display("FAIL strobes: i_rv=%0b d_rv=%0b i_dn=%0b d_dn=%0b wack=%0b at cyc %0d",
                 i_rvalid, d_rvalid, i_done, d_done, d_wack, cyc);
      end
    end
    if (i_rvalid) begin
      total++;
      if (iq.size() == 0) begin
        bad++;
        $display("FAIL i_word: unexpected word rword=%0d rdata=%h at cyc %0d", rword, rdata, cyc);
      end else begin
        ei = iq.pop_front();
        if (rword !== ei.off || rdata !== ei.data || i_done !== ei.last) begin
          bad++;
          $display("FAIL i_word: got off=%0d data=%h done=%0b expected off=%0d data=%h done=%0b",
                   rword, rdata, i_done, ei.off, ei.data, ei.last);
        end
      end
    end
    if (d_rvalid || d_wack) begin
      total++;
      if (dq.size() == 0) begin
        bad++;
        $display("FAIL d_resp: unexpected response wack=%0b rword=%0d at cyc %0d", d_wack, rword, cyc);
      end else begin
        ed = dq.pop_front();
        if (d_wack !== ed.wack ||
            (!ed.wack && (rword !== ed.off || rdata !== ed.data || d_done !== ed.last))) begin
          bad++;
          $display("FAIL d_resp: got wack=%0b off=%0d data=%h done=%0b expected wack=%0b off=%0d data=%h done=%0b",
                   d_wack, rword, rdata, d_done, ed.wack, ed.off, ed.data, ed.last);
        end
      end
    end
  end

  // I-cache driver: n fills; request held across consecutive fills unless gaps.
  task automatic iSeq(input int n, input bit dropEarly, input bit gaps);
    int waited;
    for (int k = 0; k < n; k++) begin
      i_addr    = iAddrs[k];
      i_req     = 1'b1;
      pushFill(iAddrs[k], 1'b0);
      iFirst[k] = -1;
      iDone[k]  = -1;
      waited    = 0;
      while (iDone[k] < 0 && waited < 300) begin
        @(negedge clk);
        waited++;
        if (!busy) iBusyLow++;
        if (i_rvalid && iFirst[k] < 0) iFirst[k] = cyc;
        if (dropEarly && waited == 1) i_req = 1'b0;
        if (i_done) iDone[k] = cyc;
      end
      if (iDone[k] < 0) begin
        total++;
        bad++;
        $display("FAIL i_timeout: no i_done for addr %h", iAddrs[k]);
      end
      $display("i fill addr=%h first=%0d done=%0d", iAddrs[k], iFirst[k], iDone[k]);
      if (k == n - 1) begin
        i_req = 1'b0;
      end else if (gaps && $urandom_range(0, 1) == 1) begin
        i_req = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
  endtask

  task automatic dSeq(input int n, input bit gaps);
    int waited;
    expT e;
    for (int k = 0; k < n; k++) begin
      d_addr  = dAddrA[k];
      d_wr    = dWrA[k];
      d_wdata = dDataA[k];
      d_req   = 1'b1;
      if (dWrA[k]) begin
        model[dAddrA[k][15:1]] = dDataA[k];
        e.wack = 1'b1;
        e.off  = 3'd0;
        e.data = 16'h0000;
        e.last = 1'b0;
        dq.push_back(e);
      end else begin
        pushFill(dAddrA[k], 1'b1);
      end
      dFirst[k] = -1;
      dDone[k]  = -1;
      waited    = 0;
      while (dDone[k] < 0 && waited < 300) begin
        @(negedge clk);
        waited++;
        if ((d_rvalid || d_wack) && dFirst[k] < 0) dFirst[k] = cyc;
        if (d_done || d_wack) dDone[k] = cyc;
      end
      if (dDone[k] < 0) begin
        total++;
        bad++;
        $display("FAIL d_timeout: no completion for addr %h wr=%0b", dAddrA[k], dWrA[k]);
      end
      $display("d op wr=%0b addr=%h data=%h first=%0d done=%0d",
               dWrA[k], dAddrA[k], dDataA[k], dFirst[k], dDone[k]);
      if (k == n - 1) begin
        d_req = 1'b0;
      end else if (gaps && $urandom_range(0, 1) == 1) begin
        d_req = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
  endtask

  task automatic checkIdle(input string name);
    check({name, "_rdata"}, int'(rdata), 0);
    check({name, "_ctl"}, int'({rword, i_rvalid, d_rvalid, i_done, d_done, d_wack, busy}), 0);
  endtask

  initial begin
    int g;
    int k;
    int w;
    logic [15:0] v;
    rst_n   = 1'b0;
    i_req   = 1'b0;
    i_addr  = 16'h0000;
    d_req   = 1'b0;
    d_wr    = 1'b0;
    d_addr  = 16'h0000;
    d_wdata = 16'h0000;
    for (int a = 0; a < 32768; a++) begin
      v = 16'($urandom);
      if (a >= 16'h18 && a < 16'h20) v = 16'h1000 + 16'(a - 16'h18);
      model[a]   = v;
      dut.mem[a] = v;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkIdle("reset");
    rst_n = 1'b1;

    // Isolated I fill: exact latency, done on the 8th word, busy throughout.
    @(negedge clk);
    iAddrs[0] = 16'h0036;
    g = cyc + 1;
    iSeq(1, 1'b0, 1'b0);
    check("t1_first", iFirst[0], g + LAT);
    check("t1_done", iDone[0], g + LAT + 7);
    check("t1_busy", iBusyLow, 0);

    // Same-edge tie after reset: I first, D granted on the edge ending i_done.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    iAddrs[0] = 16'h0040;
    dWrA[0] = 1'b0; dAddrA[0] = 16'h0100; dDataA[0] = 16'h0000;
    g = cyc + 1;
    fork
      iSeq(1, 1'b0, 1'b0);
      dSeq(1, 1'b0);
    join
    check("t2_i_first", iFirst[0], g + LAT);
    check("t2_d_first", dFirst[0], iDone[0] + 1 + LAT);

    // Write then fill of the same block.
    @(negedge clk);
    dWrA[0] = 1'b1; dAddrA[0] = 16'h0104; dDataA[0] = 16'hBEEF;
    dWrA[1] = 1'b0; dAddrA[1] = 16'h0100; dDataA[1] = 16'h0000;
    g = cyc + 1;
    dSeq(2, 1'b0);
    check("t3_wack", dFirst[0], g);
    check("t3_fill_first", dFirst[1], g + 1 + LAT);

    // Reset during the fourth streamed word.
    @(negedge clk);
    i_addr = 16'h0036;
    i_req  = 1'b1;
    pushFill(16'h0036, 1'b0);
    k = 0;
    w = 0;
    while (k < 4 && w < 100) begin
      @(negedge clk);
      w++;
      if (i_rvalid) k++;
    end
    check("t4_reach_word3", k, 4);
    rst_n = 1'b0;
    i_req = 1'b0;
    @(negedge clk);
    checkIdle("t4_reset");
    iq.delete();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_quiet_busy", int'(busy), 0);
    iAddrs[0] = 16'h0036;
    g = cyc + 1;
    iSeq(1, 1'b0, 1'b0);
    check("t4_restart_first", iFirst[0], g + LAT);

    // Request dropped right after the grant still completes.
    @(negedge clk);
    iAddrs[0] = 16'h0050;
    g = cyc + 1;
    iSeq(1, 1'b1, 1'b0);
    check("t5_drop_done", iDone[0], g + LAT + 7);

    // Both held continuously, I served last: D, I, D, I.
    @(negedge clk);
    iAddrs[0] = 16'h0060; iAddrs[1] = 16'h003A;
    dWrA[0] = 1'b0; dAddrA[0] = 16'h0200;
    dWrA[1] = 1'b0; dAddrA[1] = 16'hFFF0;
    g = cyc + 1;
    fork
      iSeq(2, 1'b0, 1'b0);
      dSeq(2, 1'b0);
    join
    check("t5_alt_d0", dFirst[0], g + LAT);
    check("t5_alt_i0", iFirst[0], dDone[0] + 1 + LAT);
    check("t5_alt_d1", dFirst[1], iDone[0] + 1 + LAT);
    check("t5_alt_i1", iFirst[1], dDone[1] + 1 + LAT);

    // Random concurrent traffic; D stays in a small high region for RAW hits.
    @(negedge clk);
    for (int j = 0; j < 12; j++) begin
      iAddrs[j] = 16'($urandom_range(0, 16'h7FFF));
      dWrA[j]   = ($urandom_range(0, 2) == 0);
      dAddrA[j] = 16'h8000 | 16'($urandom_range(0, 255));
      dDataA[j] = 16'($urandom);
    end
    fork
      iSeq(12, 1'b0, 1'b1);
      dSeq(12, 1'b1);
    join

    repeat (5) @(negedge clk);
    check("iq_drained", iq.size(), 0);
    check("dq_drained", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_fill_server.md
Name: mem_fill_server

Overview:
- Main-memory responder at the far end of the I-cache and D-cache miss interfaces in the pipelined CPU.
- Accepts block-fill read requests from both caches and single-word write-through stores from the D-cache.
- Arbitrates between the two requesters, models a fixed multi-cycle memory latency, and streams 8 words per block back to the requesting cache.
- Owns the backing word array; the bench preloads it hierarchically.

Parameters:
- LATENCY, 4, cycles from the grant edge to the first returned word (legal range 1..15).
- BLOCK_WORDS, 8, words per cache block (fixed 8; 16-byte block).
- MEM_AW, 15, word-address width of the backing array (2^15 x 16 bit).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- i_req  in  1  I-cache fill request, level, held until i_done
- i_addr  in  16  I-cache miss byte address
- d_req  in  1  D-cache request, level, held until d_done or d_wack
- d_wr  in  1  1 = single-word write, 0 = block fill
- d_addr  in  16  D-cache byte address
- d_wdata  in  16  write data
- rdata  out  16  returned fill word
- rword  out  3  block offset (word index) of rdata
- i_rvalid  out  1  rdata belongs to the I-cache fill
- d_rvalid  out  1  rdata belongs to the D-cache fill
- i_done  out  1  pulse with the last I-cache word
- d_done  out  1  pulse with the last D-cache word
- d_wack  out  1  write-complete pulse
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: the synchronous rst_n is active-low. All outputs are 0 and rdata is 0. FSM goes to IDLE, counters clear, and the last-served flag is set to D. Memory contents are untouched.
- Reset mid-operation: the in-flight fill is dropped with no further valid or done pulses. A write not yet granted never occurs.
- Addressing: word index = addr[15:1] (addr[0] ignored). Block base = {addr[15:4], 4'b0}. Offset = addr[3:1].
- FSM states: IDLE, WAIT, STREAM, WRITE.
- IDLE arbitration, sampled at each edge:
  - If only one request is present, it is granted.
  - If both are present, the requester not served last is granted (round-robin anti-starvation); after reset, I wins the first tie.
  - The grant edge latches the requester, the address, d_wr, and d_wdata. Later input changes are ignored until completion.
- Write grant:
  - The array is written on the grant edge and the FSM goes to WRITE.
  - d_wack is high for exactly the following cycle. The FSM then returns to IDLE, and a new grant may occur on that same edge.
- Fill grant:
  - The FSM enters WAIT with the latency counter set to LATENCY-1.
  - When the counter reaches 0, the FSM enters STREAM.
  - The first word is valid during the cycle starting LATENCY edges after the grant.
  - STREAM presents 8 words on 8 consecutive cycles with the matching x_rvalid high. rword gives each word's offset, and rdata = mem[base+offset].
  - x_done is high together with the 8th word. The edge ending that cycle returns to IDLE and may grant a new request (zero bubble).
  - Total occupancy is LATENCY+8 cycles.
- Read-after-write: a fill granted after a write's grant edge returns the written data.
- Deassertion: if a requester drops its request mid-transaction, the transaction still completes (no cancel).
- Invalid combination: a requester asserting its request while a done/wack pulse is high for that same requester is treated as a new request.
- Stream order: offsets 0..7 ascending unless the optional feature is enabled.
- Offset counter: 3 bits and wraps naturally. The block never crosses a 16-byte boundary, and address 0xFFF0 serves words 0xFFF0..0xFFFE.
- Valid strobes: i_rvalid and d_rvalid are never high together.

Optional Feature:
- Macro CRITICAL_WORD_FIRST_EN.
- When defined: a fill returns the requested offset first, then wraps modulo 8 within the block. Example: offset 5 gives 5,6,7,0,1,2,3,4. rword always reports the actual offset, and done still goes high on the 8th word.
- When not defined: order is always 0..7 and the requested offset is ignored for ordering.
- Latency and occupancy are identical in both builds.

Test Plan:
- Reset preload: mem[0x18+k]=0x1000+k. i_req with i_addr=0x0036 at grant edge E0, LATENCY=4 -> i_rvalid cycles E0+4..E0+11. rword 0..7, rdata 0x1000..0x1007, i_done only in the cycle of E0+11. busy high throughout.
- Same edge arbitration: i_req and d_req (fill, d_addr=0x0100) both first asserted at the same edge after reset -> I served first. D granted on the edge ending i_done, and d_rvalid first appears 4 cycles later. No overlap of the valid strobes.
- Write then fill: d_wr=1, d_addr=0x0104, d_wdata=0xBEEF -> d_wack exactly 1 cycle later. A following fill of 0x0100 returns 0xBEEF at rword=2.
- Reset mid-fill: pulse rst_n low during STREAM word 3 -> from the next edge all outputs are 0 and busy=0. No done pulse occurs. A re-issued request restarts with full latency.
- Drop and back-to-back: i_req drops after the grant -> all 8 words are still returned. With both requesters continuously asserted, grants alternate D,I,D,I.
- CRITICAL_WORD_FIRST_EN defined, fill of 0x003A -> rword sequence 5,6,7,0,1,2,3,4. rdata matches mem[0x18+rword]. done high with the rword=4 word.
